// File: rtl/apb_master_nslv.sv
// apb_master_nslv: APB3 master bridging a transfer/ready CPU data bus to NUM_SLV APB slaves.
// One CPU request is latched in IDLE. The slave index comes from the address, and the bridge
// runs the SETUP and ACCESS phases. It returns registered rdata/ready/error. Out-of-window
// addresses complete with an error and cause no APB activity.
//
// Ports
//   PCLK, PRESET              clock (rising edge), asynchronous active-low reset
//   transfer/write/addr/wdata CPU request, sampled only in IDLE
//   rdata/ready/error         CPU response; ready and error are one-cycle pulses
//   PADDR/PWRITE/PWDATA       APB request fields, held between transfers
//   PSEL/PENABLE              one-hot slave select and enable
//   PRDATA/PREADY/PSLVERR     per-slave responses; only the selected slave is observed
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYC stalled cycles.
module apb_master_nslv #(
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = ADDR_W'(32'h1000_0000),
  parameter int unsigned          SLV_AW      = 12,
  parameter int unsigned          TIMEOUT_CYC = 255
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        transfer,
  input  logic                        write,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata,
  output logic                        ready,
  output logic                        error,
  output logic [ADDR_W-1:0]           PADDR,
  output logic                        PWRITE,
  output logic [DATA_W-1:0]           PWDATA,
  output logic                        PENABLE,
  output logic [NUM_SLV-1:0]          PSEL,
  input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]          PREADY,
  input  logic [NUM_SLV-1:0]          PSLVERR
);

  localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  // Elaboration-time parameter sanity check
  if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("apb_master_nslv: illegal NUM_SLV or TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DECERR = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                penable_q, penable_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc_c;
  assign cnt_inc_c = cnt_q + 1'b1;
`endif

  // Address decode: unsigned offset from the window base, index compared at full width
  logic [ADDR_W-1:0]   off_c, idx_full_c;
  logic                in_win_c;
  logic [IDX_W-1:0]    idx_new_c;

  assign off_c      = addr - BASE_ADDR;
  assign idx_full_c = off_c >> SLV_AW;
  assign in_win_c   = (addr >= BASE_ADDR) && (idx_full_c < ADDR_W'(NUM_SLV));
  assign idx_new_c  = IDX_W'(idx_full_c);

  // Response of the currently addressed slave
  logic                sel_ready_c, sel_err_c;
  logic [DATA_W-1:0]   sel_rdata_c;

  assign sel_ready_c = PREADY[idx_q];
  assign sel_err_c   = PSLVERR[idx_q];
  assign sel_rdata_c = PRDATA[int'(idx_q)*DATA_W +: DATA_W];

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          paddr_d  = addr;
          pwrite_d = write;
          pwdata_d = wdata;
          if (in_win_c) begin
            idx_d   = idx_new_c;
            psel_d  = NUM_SLV'(1) << idx_new_c;
            state_d = S_SETUP;
`ifdef APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = S_DECERR;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready_c) begin
          ready_d   = 1'b1;
          error_d   = sel_err_c;
          if (!pwrite_q) rdata_d = sel_rdata_c;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else begin
          cnt_d = cnt_inc_c;
          // Stalled for TIMEOUT_CYC access cycles: abandon the transfer
          if (cnt_inc_c == CNT_W'(TIMEOUT_CYC)) begin
            ready_d   = 1'b1;
            error_d   = 1'b1;
            rdata_d   = '0;
            psel_d    = '0;
            penable_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
`endif
      end
      S_DECERR: begin
        ready_d = 1'b1;
        error_d = 1'b1;
        rdata_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign error   = error_q;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Testbench for apb_master_nslv: transaction-level model of the expected bus timeline,
// compared against the DUT outputs on every falling clock edge.
module tb_apb_master_nslv;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned NS   = 4;
  localparam int unsigned SAW  = 12;
  localparam int unsigned TO   = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic           PCLK = 1'b0;
  logic           PRESET;
  logic           transfer, write;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wdata, rdata;
  logic           ready, error;
  logic [AW-1:0]  PADDR;
  logic           PWRITE, PENABLE;
  logic [DW-1:0]  PWDATA;
  logic [NS-1:0]  PSEL, PREADY, PSLVERR;
  logic [NS*DW-1:0] PRDATA;

  apb_master_nslv #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .BASE_ADDR(BASE),
    .SLV_AW(SAW), .TIMEOUT_CYC(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .error(error),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Expected per-cycle outputs and held model state
  logic [NS-1:0] e_psel;
  logic          e_penable, e_ready, e_error;
  logic [AW-1:0] m_paddr;
  logic          m_pwrite;
  logic [DW-1:0] m_pwdata, m_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("PSEL",    64'(PSEL),    64'(e_psel));
      chk("PENABLE", 64'(PENABLE), 64'(e_penable));
      chk("ready",   64'(ready),   64'(e_ready));
      chk("error",   64'(error),   64'(e_error));
      chk("PADDR",   64'(PADDR),   64'(m_paddr));
      chk("PWRITE",  64'(PWRITE),  64'(m_pwrite));
      chk("PWDATA",  64'(PWDATA),  64'(m_pwdata));
      chk("rdata",   64'(rdata),   64'(m_rdata));
    end
  end

  // Unselected slaves and non-sampled cycles carry random noise
  task automatic rand_bus();
    PREADY  = NS'($urandom);
    PSLVERR = NS'($urandom);
    for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = $urandom;
  endtask

  task automatic busy_noise();
    transfer = 1'($urandom);
    write    = 1'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
    rand_bus();
  endtask

  task automatic idle_cycle();
    step();
    transfer  = 1'b0;
    e_psel    = '0;
    e_penable = 1'b0;
    e_ready   = 1'b0;
    e_error   = 1'b0;
  endtask

  // Issue one request in the current (IDLE) cycle; return in its completion cycle.
  // waits = stalled ACCESS cycles before PREADY; rst_at = ACCESS cycle that gets a reset (-1 none).
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input bit serr, input logic [31:0] rd, input int rst_at);
    logic [31:0] off;
    int idx;
    bit hit;
    off = a - BASE;
    idx = int'(off >> SAW);
    hit = (a >= BASE) && ((off >> SAW) < 32'(NS));
    transfer = 1'b1; write = wr; addr = a; wdata = wd;

    step(); busy_noise();
    m_paddr = a; m_pwrite = wr; m_pwdata = wd;
    e_ready = 1'b0; e_error = 1'b0; e_penable = 1'b0;
    if (!hit) begin
      e_psel = '0;
      step(); transfer = 1'b0;
      e_ready = 1'b1; e_error = 1'b1; m_rdata = '0;
      return;
    end
    e_psel = NS'(1 << idx);

    for (int c = 0; ; c++) begin
      step(); busy_noise();
      e_penable = 1'b1;
`ifdef APB_TIMEOUT_EN
      if (c == int'(TO)) begin
        transfer = 1'b0;
        e_psel = '0; e_penable = 1'b0;
        e_ready = 1'b1; e_error = 1'b1; m_rdata = '0;
        return;
      end
`endif
      if (c == rst_at) begin
        PREADY[idx] = 1'b0;
        PRESET = 1'b0;
        e_psel = '0; e_penable = 1'b0; e_ready = 1'b0; e_error = 1'b0;
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_rdata = '0;
        step();
        PRESET = 1'b1;
        transfer = 1'b0;
        return;
      end
      PREADY[idx] = (c == waits);
      PSLVERR[idx] = serr;
      PRDATA[idx*DW +: DW] = rd;
      if (c == waits) break;
    end

    step(); transfer = 1'b0;
    e_psel = '0; e_penable = 1'b0;
    e_ready = 1'b1; e_error = serr;
    if (!wr) m_rdata = rd;
  endtask

  task automatic gaps(input int n);
    for (int i = 0; i < n; i++) idle_cycle();
  endtask

  initial begin
    PRESET = 1'b0;
    transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    PREADY = '0; PSLVERR = '0; PRDATA = '0;
    e_psel = '0; e_penable = 1'b0; e_ready = 1'b0; e_error = 1'b0;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_rdata = '0;
    chk_en = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    chk("reset_psel", 64'(PSEL), 64'h0);
    chk("reset_rdata", 64'(rdata), 64'h0);
    gaps(1);

    // Zero-wait write to slave 1
    run_txn(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 0, 1'b0, $urandom, -1);
    chk("lit_wr_ready", 64'(ready), 64'h1);
    chk("lit_wr_error", 64'(error), 64'h0);
    chk("lit_wr_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
    chk("lit_wr_paddr", 64'(PADDR), 64'h1000_1004);
    gaps(1);

    // Read from slave 3 with three wait states
    run_txn(1'b0, 32'h1000_3010, $urandom, 3, 1'b0, 32'h1234_5678, -1);
    chk("lit_rd_rdata", 64'(rdata), 64'h1234_5678);
    chk("lit_rd_ready", 64'(ready), 64'h1);
    gaps(1);

    // Decode miss just above the last window, then slave error and back-to-back issue
    run_txn(1'b0, 32'h1000_4000, $urandom, 0, 1'b0, $urandom, -1);
    chk("lit_dec_error", 64'(error), 64'h1);
    chk("lit_dec_rdata", 64'(rdata), 64'h0);
    gaps(1);
    run_txn(1'b1, 32'h1000_2008, 32'h0BAD_F00D, 0, 1'b1, $urandom, -1);
    chk("lit_serr_error", 64'(error), 64'h1);
    run_txn(1'b0, 32'h1000_0000, $urandom, 0, 1'b0, 32'hCAFE_F00D, -1);
    chk("lit_b2b_rdata", 64'(rdata), 64'hCAFE_F00D);
    chk("lit_b2b_error", 64'(error), 64'h0);
    gaps(1);

    // Reset during ACCESS, then a normal transfer
    run_txn(1'b0, 32'h1000_2000, $urandom, 5, 1'b0, 32'hAAAA_5555, 1);
    chk("lit_rst_psel", 64'(PSEL), 64'h0);
    chk("lit_rst_ready", 64'(ready), 64'h0);
    gaps(2);
    run_txn(1'b0, 32'h1000_2004, $urandom, 1, 1'b0, 32'h5555_AAAA, -1);
    chk("lit_post_rst_rdata", 64'(rdata), 64'h5555_AAAA);
    gaps(1);

    // Window boundaries
    run_txn(1'b0, 32'h0FFF_FFFC, $urandom, 0, 1'b0, $urandom, -1);
    chk("lit_below_error", 64'(error), 64'h1);
    run_txn(1'b0, 32'h1000_3FFC, $urandom, 0, 1'b0, 32'h0000_0FFC, -1);
    chk("lit_last_rdata", 64'(rdata), 64'h0000_0FFC);
    run_txn(1'b1, 32'hFFFF_FFFC, $urandom, 0, 1'b0, $urandom, -1);
    chk("lit_top_error", 64'(error), 64'h1);
    gaps(1);

`ifdef APB_TIMEOUT_EN
    // Stuck slave aborts; one stall short of the limit completes normally
    run_txn(1'b0, 32'h1000_1000, $urandom, 1000, 1'b0, $urandom, -1);
    chk("lit_to_error", 64'(error), 64'h1);
    chk("lit_to_rdata", 64'(rdata), 64'h0);
    chk("lit_to_psel", 64'(PSEL), 64'h0);
    gaps(1);
    run_txn(1'b0, 32'h1000_1000, $urandom, int'(TO) - 1, 1'b0, 32'h7777_0001, -1);
    chk("lit_to_edge_error", 64'(error), 64'h0);
    gaps(1);
`endif

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int r, w;
      r = int'($urandom % 100);
      if (r < 70)      a = BASE + (($urandom % NS) << SAW) + (($urandom % 1024) << 2);
      else if (r < 85) a = $urandom % BASE;
      else             a = 32'h1000_4000 + ($urandom & 32'h0FFF_FFFC);
      w = int'($urandom % 6);
`ifdef APB_TIMEOUT_EN
      if ($urandom % 10 == 0) w = 12;
`endif
      run_txn(1'($urandom), a, $urandom, w, ($urandom % 5) == 0, $urandom, -1);
      if ($urandom % 2 == 0) gaps(int'($urandom % 2) + 1);
    end

    gaps(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
